ysyx_25040105_mem_arbiter: RTL and testbench
============================================

# ysyx_25040105_mem_arbiter

Two-master, one-slave memory arbiter for the multi-cycle core. It sits between the IFU instruction-fetch port and the LSU data port on one side and a single memory port on the other. It grants one outstanding transaction at a time, with round-robin tie-breaking. Each transaction is guarded by a response timeout that returns an error instead of hanging the core.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before an error response (≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ifu_req_valid / ifu_req_ready  in/out  1  IFU request handshake (read only)
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid / ifu_resp_ready  out/in  1  IFU response handshake
- ifu_rdata  out  DATA_W  fetched word
- ifu_resp_err  out  1  timeout error flag
- lsu_req_valid / lsu_req_ready  in/out  1  LSU request handshake
- lsu_addr  in  ADDR_W  data address
- lsu_wen  in  1  1 = write
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  DATA_W/8  byte strobes
- lsu_resp_valid / lsu_resp_ready  out/in  1  LSU response handshake
- lsu_rdata  out  DATA_W  read data
- lsu_resp_err  out  1  timeout error flag
- mem_req_valid / mem_req_ready  out/in  1  memory request handshake
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  as LSU  latched request fields
- mem_resp_valid / mem_resp_ready  in/out  1  memory response handshake
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states:
  - IDLE: accepts a new request.
  - REQ: presents the request to memory.
  - WAIT: waits for the memory response.
  - RESP: holds the response for the owner.
- IDLE arbitration, combinational:
  - Only one valid: grant that master.
  - Both valid: grant the master not in `last_grant`.
  - `req_ready` is 1 only for the granted master, and only in IDLE.
- Request handshake (`valid & ready`) in IDLE:
  - Latch addr, wen, wdata, wmask and owner; set `last_grant` = owner; go to REQ.
  - IFU requests latch wen=0, wdata=0, wmask=0.
- REQ:
  - mem_req_valid=1 with the latched fields.
  - On mem_req_ready, go to WAIT.
- WAIT:
  - mem_resp_ready=1.
  - On mem_resp_valid, latch mem_rdata, set err=0, go to RESP.
- RESP:
  - Owner's resp_valid=1 with the latched rdata/err; the other master's resp_valid=0.
  - On the owner's resp_ready, go to IDLE.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT-1 without completion, go to RESP with err=1 and rdata=0, and drop mem_req_valid.
  - Completion on the same cycle as the timeout wins (err=0).
- Stale responses: mem_resp_ready=1 in IDLE as well; any mem_resp_valid outside WAIT is consumed and discarded.
- Writes complete on mem_resp_valid like reads; rdata is forwarded unchanged.
- A new request is never accepted while in RESP, so there is at most one outstanding transaction.

## Timing
- Reset values (rst low, asynchronous):
  - State IDLE, `last_grant`=IFU, counter=0.
  - All *_valid and *_ready outputs 0, except the combinational IDLE req_ready/mem_resp_ready, which follow their rules.
  - Latched fields and rdata 0; err flags 0.
- Reset asserted mid-transaction: immediate return to IDLE. The response is lost and no resp_valid is produced.
- Minimum latency with mem_req_ready and mem_resp_valid zero-wait:
  - Cycle 0: handshake.
  - Cycle 1: mem_req_valid.
  - Cycle 2: mem_resp accepted.
  - Cycle 3: resp_valid.
  - Cycle 4: earliest next handshake. This gives a 4-cycle throughput per transaction.
- Outputs are registered from state/latches; req_ready is the only combinational path from master valids.
- Request fields on mem_* are stable while mem_req_valid=1.

## Test plan
- Single IFU read:
  - Stimulus: ifu addr 0x8000_0000; memory returns 0x0010_0073 with zero wait.
  - Required: ifu_resp_valid at cycle 3 with rdata 0x0010_0073, err=0; lsu_resp_valid stays 0.
- Simultaneous requests after reset:
  - Stimulus: IFU and LSU both valid in the same cycle, held valid.
  - Required: LSU is granted first (last_grant=IFU), IFU next, then LSU, alternating.
- LSU write:
  - Stimulus: addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 4'b0011.
  - Required: mem_* carry exactly these fields with mem_wen=1 until mem_req_ready; lsu_resp_valid follows mem_resp_valid by 1 cycle.
- Backpressure:
  - Stimulus: mem_req_ready low for 5 cycles, mem_resp_valid delayed 3 cycles, ifu_resp_ready low for 4 cycles.
  - Required: all held signals stay stable; no second grant occurs until the response handshake completes.
- Timeout:
  - Stimulus: TIMEOUT=8, memory never responds.
  - Required: resp_valid after 8 cycles in REQ/WAIT with err=1, rdata=0; a later stray mem_resp_valid in IDLE is discarded with no resp_valid.
- Reset in WAIT:
  - Stimulus: drop rst during WAIT.
  - Required: all outputs return to reset values asynchronously; after release, the next request completes normally.

Source files
------------

// File: rtl/ysyx_25040105_mem_arbiter.sv
// IFU/LSU to single memory port arbiter: one outstanding transaction, round-robin grant, response timeout.
// Latency: handshake -> resp_valid in 3 cycles min; req_ready only in IDLE, response held until owner's resp_ready.
module ysyx_25040105_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              owner;       // 0 = IFU, 1 = LSU
  logic              last_grant;  // 0 = IFU, 1 = LSU
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic grant_lsu;
  logic ifu_fire;
  logic lsu_fire;
  logic timeout_hit;
  logic owner_resp_ready;

  // On a tie the master that did not win last time gets the grant.
  always_comb begin
    grant_lsu = lsu_req_valid;
    if (ifu_req_valid && lsu_req_valid) begin
      grant_lsu = ~last_grant;
    end
  end

  assign ifu_req_ready    = (state == IDLE) && ifu_req_valid && !grant_lsu;
  assign lsu_req_ready    = (state == IDLE) && grant_lsu;
  assign ifu_fire         = ifu_req_valid && ifu_req_ready;
  assign lsu_fire         = lsu_req_valid && lsu_req_ready;
  assign timeout_hit      = (cnt == CNT_LAST);
  assign owner_resp_ready = owner ? lsu_resp_ready : ifu_resp_ready;

  assign ifu_rdata    = rdata_q;
  assign lsu_rdata    = rdata_q;
  assign ifu_resp_err = err_q;
  assign lsu_resp_err = err_q;

  always_comb begin
    state_nxt      = state;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b1;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (ifu_fire || lsu_fire) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (timeout_hit) begin
          state_nxt = RESP;
        end else if (mem_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A response on the last allowed cycle still counts as completion.
        if (mem_resp_valid || timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        mem_resp_ready = 1'b0;
        ifu_resp_valid = ~owner;
        lsu_resp_valid = owner;
        if (owner_resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (lsu_fire) begin
            mem_addr   <= lsu_addr;
            mem_wen    <= lsu_wen;
            mem_wdata  <= lsu_wdata;
            mem_wmask  <= lsu_wmask;
            owner      <= 1'b1;
            last_grant <= 1'b1;
          end else if (ifu_fire) begin
            mem_addr   <= ifu_addr;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b0;
          end
        end
        REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_resp_valid) begin
            rdata_q <= mem_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040105_mem_arbiter.sv
// Transaction-level bench for the memory arbiter: directed cases plus randomized traffic against a timing/grant model.
module tb_ysyx_25040105_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int n_chk = 0;
  int n_err = 0;
  bit last_lsu;  // model: master granted most recently (0 = IFU)

  always #5 clk = ~clk;

  ysyx_25040105_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
    chk({tag, "_req_ready"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
    chk({tag, "_resp_valid"}, {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    chk({tag, "_mem_resp_ready"}, mem_resp_ready, 1'b1);
    chk({tag, "_mem_fields"}, {mem_addr, mem_wen, mem_wdata, mem_wmask}, '0);
    chk({tag, "_rdata_err"}, {ifu_rdata, ifu_resp_err, lsu_rdata, lsu_resp_err}, '0);
  endtask

  // One transaction, entered and left at a negedge with the arbiter idle.
  // rqw: cycles mem_req_ready held low, rsw: cycles before mem_resp_valid,
  // rrw: cycles the owner holds resp_ready low. The model allows rqw+rsw+2
  // cycles in REQ/WAIT; beyond TO the memory stays silent and an error is due.
  task automatic run_txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                         input bit lw, input logic [31:0] wd, input logic [3:0] wm,
                         input int rqw, input int rsw, input int rrw, input logic [31:0] md);
    bit          own_lsu;
    bit          ok;
    int          total;
    int          n;
    logic [31:0] exp_rd;
    logic [68:0] fld;
    own_lsu = (iv && lv) ? !last_lsu : lv;
    total   = rqw + rsw + 2;
    ok      = (total <= TO);
    n       = ok ? total : TO;
    exp_rd  = ok ? md : 32'h0;
    fld     = own_lsu ? {la, lw, wd, wm} : {ia, 1'b0, 32'h0, 4'h0};

    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = wd; lsu_wmask = wm;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    #1;
    chk("grant_ifu_ready", ifu_req_ready, !own_lsu);
    chk("grant_lsu_ready", lsu_req_ready, own_lsu);
    chk("idle_mem_req_valid", mem_req_valid, 1'b0);
    last_lsu = own_lsu;

    for (int t = 1; t <= n; t++) begin
      @(negedge clk);
      if (own_lsu) lsu_req_valid = 1'b0;
      else ifu_req_valid = 1'b0;
      chk("busy_req_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
      chk("busy_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
      chk("mem_req_valid", mem_req_valid, (t <= rqw + 1));
      if (t <= rqw + 1) chk("mem_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, fld);
      else chk("wait_mem_resp_ready", mem_resp_ready, 1'b1);
      mem_req_ready  = (t == rqw + 1);
      mem_resp_valid = ok && (t == total);
      mem_rdata      = (ok && t == total) ? md : $urandom;
    end

    for (int r = 0; r <= rrw; r++) begin
      @(negedge clk);
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      chk("resp_valid", {ifu_resp_valid, lsu_resp_valid}, own_lsu ? 2'b01 : 2'b10);
      chk("resp_data_err", own_lsu ? {lsu_rdata, lsu_resp_err} : {ifu_rdata, ifu_resp_err}, {exp_rd, !ok});
      chk("resp_mem_req_valid", mem_req_valid, 1'b0);
      chk("resp_req_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
      if (own_lsu) begin
        lsu_resp_ready = (r == rrw); ifu_resp_ready = 1'($urandom);
      end else begin
        ifu_resp_ready = (r == rrw); lsu_resp_ready = 1'($urandom);
      end
    end
    @(negedge clk);
    ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    chk("after_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
  endtask

  initial begin
    int sel;
    rst = 1'b0;
    ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_resp_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    last_lsu = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    @(negedge clk);

    // both held valid after reset: LSU, IFU, LSU, IFU
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 32'h8000_0000 + 32'(i * 4), 32'h8000_1000 + 32'(i * 4), 1'(i), $urandom, 4'hF, 0, 0, 0, $urandom);

    run_txn(1, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0010_0073);
    run_txn(0, 1, 0, 32'h8000_0100, 1, 32'hDEAD_BEEF, 4'b0011, 2, 0, 0, 32'h1234_5678);

    // backpressure on each side, and a tie held through a stalled transaction
    run_txn(1, 0, 32'h8000_0200, 0, 0, 0, 0, 5, 0, 0, 32'hA5A5_0001);
    run_txn(0, 1, 0, 32'h8000_0204, 0, 32'h1111_2222, 4'hF, 0, 3, 4, 32'hA5A5_0002);
    run_txn(1, 1, 32'h8000_0208, 32'h8000_020C, 1, 32'h3333_4444, 4'b1100, 5, 0, 4, 32'hA5A5_0003);

    // completion on the last allowed cycle, then one cycle too late
    run_txn(1, 0, 32'h8000_0210, 0, 0, 0, 0, 3, 3, 1, 32'hC0DE_0008);
    run_txn(0, 1, 0, 32'h8000_0214, 0, 0, 4'hF, 3, 4, 0, 32'hC0DE_0009);

    // memory never answers, then a stray response arrives in IDLE
    run_txn(1, 0, 32'h8000_0300, 0, 0, 0, 0, 0, 50, 1, 32'hBAD0_0000);
    mem_resp_valid = 1'b1; mem_rdata = 32'hFEED_FACE;
    chk("stray_mem_resp_ready", mem_resp_ready, 1'b1);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stray_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
      chk("stray_mem_req_valid", mem_req_valid, 1'b0);
      @(negedge clk);
    end
    run_txn(0, 1, 0, 32'h8000_0304, 1, 32'h5555_6666, 4'h1, 12, 0, 0, 32'hBAD0_0001);

    // reset dropped while waiting for the memory response
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    chk("rw_req_valid", mem_req_valid, 1'b1);
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rw_wait_req_valid", mem_req_valid, 1'b0);
    chk("rw_wait_resp_ready", mem_resp_ready, 1'b1);
    #2 rst = 1'b0;
    #1 check_reset("rst_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; last_lsu = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("rw_lost_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    @(negedge clk);
    chk("rw_lost_resp2", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    run_txn(1, 1, 32'h8000_0400, 32'h8000_0404, 0, 0, 4'hF, 0, 0, 0, 32'h7777_8888);

    for (int j = 0; j < 40; j++) begin
      sel = int'($urandom_range(1, 3));
      run_txn(sel[0], sel[1], $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
